eth_wol_poll_ctrl: RTL

//  Avalon-MM master sequencer for the 1-bit Ethernet WOL edge-capture PIO slave.

---
 rtl/eth_wol_poll_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/eth_wol_poll_ctrl.sv
// eth_wol_poll_ctrl: Avalon-MM master that polls a 1-bit Wake-on-LAN
// edge-capture PIO, clears captured edges and raises a sticky wake interrupt.
//
// state  | meaning
// IDLE   | poll timer runs while enabled, bus quiet
// RD_LVL | read level register (addr 0)
// LVL_W  | latch pin level from readdata
// RD_CAP | read edge-capture register (addr 3)
// CAP_W  | decide on captured edge
// CLR    | write 0 to addr 3, clearing the captured edge
// WAKE   | wake pulse, set irq, bump event count
// HOLD   | holdoff window, bus quiet
// FLUSH  | write addr 3 again, dropping edges seen during holdoff
module eth_wol_poll_ctrl #(
  parameter int POLL_DIV    = 50000,
  parameter int HOLDOFF_CYC = 5000000,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             irq_ack,
  output logic             pio_chipselect,
  output logic [1:0]       pio_address,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  output logic             pin_level,
  output logic             wake_pulse,
  output logic             wake_irq,
  output logic [CNT_W-1:0] wol_count,
  output logic             busy
);

  // One timer serves both the poll interval (counting up in IDLE) and the
  // holdoff window (counting down in HOLD), so it is sized for the larger.
  localparam int TMAX = (POLL_DIV > HOLDOFF_CYC) ? POLL_DIV : HOLDOFF_CYC;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] POLL_TC = TW'(POLL_DIV - 1);
  localparam logic [TW-1:0] HOLD_TC = TW'(HOLDOFF_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_LVL, S_LVL_W, S_RD_CAP, S_CAP_W, S_CLR, S_WAKE, S_HOLD, S_FLUSH
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  // Only bit 0 of the PIO carries information.
  logic unused_rd;
  assign unused_rd     = ^pio_readdata[31:1];
  assign pio_writedata = 32'd0;

  // Sequencer: state, timer and every registered output. Bus strobes are
  // loaded on the transition into an access state so they are valid for
  // exactly that state's cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      timer          <= '0;
      pio_chipselect <= 1'b0;
      pio_address    <= 2'd0;
      pio_write_n    <= 1'b1;
      pin_level      <= 1'b0;
      wake_pulse     <= 1'b0;
      wake_irq       <= 1'b0;
      wol_count      <= '0;
      busy           <= 1'b0;
    end else begin
      pio_chipselect <= 1'b0;
      pio_address    <= 2'd0;
      pio_write_n    <= 1'b1;
      wake_pulse     <= 1'b0;

      // A wake in the same cycle as an ack keeps the interrupt set.
      if (state == S_WAKE) wake_irq <= 1'b1;
      else if (irq_ack)    wake_irq <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!enable) begin
            timer <= '0;
          end else if (timer == POLL_TC) begin
            timer          <= '0;
            state          <= S_RD_LVL;
            pio_chipselect <= 1'b1;
            busy           <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_RD_LVL: state <= S_LVL_W;
        S_LVL_W: begin
          pin_level      <= pio_readdata[0];
          state          <= S_RD_CAP;
          pio_chipselect <= 1'b1;
          pio_address    <= 2'd3;
        end
        S_RD_CAP: state <= S_CAP_W;
        S_CAP_W: begin
          if (pio_readdata[0]) begin
            state          <= S_CLR;
            pio_chipselect <= 1'b1;
            pio_address    <= 2'd3;
            pio_write_n    <= 1'b0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_CLR: begin
          state      <= S_WAKE;
          wake_pulse <= 1'b1;
        end
        S_WAKE: begin
          if (wol_count != {CNT_W{1'b1}}) wol_count <= wol_count + CNT_W'(1);
          timer <= HOLD_TC;
          state <= S_HOLD;
        end
        S_HOLD: begin
          // Timer lands on 0 here, which is also the IDLE start value.
          if (timer == '0) begin
            state          <= S_FLUSH;
            pio_chipselect <= 1'b1;
            pio_address    <= 2'd3;
            pio_write_n    <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_FLUSH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          timer <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
